// File: rtl/data_mem_hs.sv
// Byte-addressable data memory behind a valid/ready request/response handshake.
// Misaligned accesses that straddle two storage words take an extra beat.
module data_mem_hs #(
  parameter int REG_WIDTH  = 64,
  parameter int ADDR_WIDTH = 10,
  parameter int LANES      = REG_WIDTH / 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic                 req_unsigned,
  input  logic [1:0]           req_width,
  input  logic [REG_WIDTH-1:0] req_addr,
  input  logic [REG_WIDTH-1:0] req_wdata,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [REG_WIDTH-1:0] resp_rdata,
  output logic                 resp_err
);
  localparam int MEM_DEPTH = 2 ** ADDR_WIDTH;
  localparam int WORDS     = MEM_DEPTH / LANES;
  localparam int OFF_W     = $clog2(LANES);
  localparam int IDX_W     = ADDR_WIDTH - OFF_W;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  state_t                state;
  logic [LANES-1:0][7:0] mem [WORDS];

  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic                  unsigned_q;
  logic                  cross_q;
  logic [3:0]            size_q;
  logic [LANES-1:0][7:0] wdata_q;
  logic [LANES-1:0][7:0] buf_q;

  logic [3:0]            req_size;
  logic [ADDR_WIDTH:0]   req_last;
  logic                  req_fault;
  logic                  req_cross;
  logic                  accept;

  logic                  in_beat;
  logic [IDX_W-1:0]      word_idx;
  logic [LANES-1:0][7:0] rd_word;
  logic [LANES-1:0][7:0] wr_word;
  logic [LANES-1:0][7:0] assembled;
  logic [LANES-1:0]      byte_we;

  // A request faults when it addresses past the end of storage or asks for a
  // width wider than the data path; faulted requests never touch memory.
  always_comb begin
    req_size  = 4'd1 << req_width;
    req_last  = {1'b0, req_addr[ADDR_WIDTH-1:0]} + (ADDR_WIDTH + 1)'(req_size - 4'd1);
    req_fault = (|req_addr[REG_WIDTH-1:ADDR_WIDTH]) || req_last[ADDR_WIDTH] ||
                (REG_WIDTH == 32 && req_width == 2'd3);
    req_cross = (int'(req_addr[OFF_W-1:0]) + int'(req_size)) > LANES;
    accept    = req_ready && req_valid;
  end

  // pos is the byte index within the access that lands on lane l this beat.
  always_comb begin
    int pos;
    in_beat   = (state == BEAT0) || (state == BEAT1);
    word_idx  = addr_q[ADDR_WIDTH-1:OFF_W] + IDX_W'(state == BEAT1);
    rd_word   = mem[word_idx];
    wr_word   = '0;
    byte_we   = '0;
    assembled = buf_q;
    for (int l = 0; l < LANES; l++) begin
      pos = (state == BEAT1) ? l + LANES - int'(addr_q[OFF_W-1:0])
                             : l - int'(addr_q[OFF_W-1:0]);
      if (in_beat && pos >= 0 && pos < int'(size_q)) begin
        byte_we[l]                   = write_q;
        wr_word[l]                   = wdata_q[pos[OFF_W-1:0]];
        assembled[pos[OFF_W-1:0]]    = rd_word[l];
      end
    end
  end

  function automatic logic [REG_WIDTH-1:0] extend(input logic [LANES-1:0][7:0] bytes,
                                                  input logic [3:0]            size,
                                                  input logic                  zero_ext);
    logic                 fill;
    logic [REG_WIDTH-1:0] res;
    fill = 1'b0;
    for (int j = 0; j < LANES; j++)
      if (j == int'(size) - 1) fill = ~zero_ext & bytes[j][7];
    for (int j = 0; j < LANES; j++)
      res[j*8 +: 8] = (j < int'(size)) ? bytes[j] : {8{fill}};
    return res;
  endfunction

  // NOTE: storage is deliberately left out of reset so it maps onto plain RAM;
  // a beat in progress when rst arrives is simply not written.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int l = 0; l < LANES; l++)
        if (byte_we[l]) mem[word_idx][l] <= wr_word[l];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      addr_q     <= req_addr[ADDR_WIDTH-1:0];
      write_q    <= req_write;
      unsigned_q <= req_unsigned;
      size_q     <= req_size;
      wdata_q    <= req_wdata;
      cross_q    <= req_cross;
      buf_q      <= '0;
    end else if (!rst && in_beat) begin
      buf_q <= assembled;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      unique case (state)
        IDLE: if (req_valid) begin
          req_ready <= 1'b0;
          if (req_fault) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end else begin
            state <= BEAT0;
          end
        end
        BEAT0, BEAT1: begin
          if (state == BEAT0 && cross_q) begin
            state <= BEAT1;
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= write_q ? '0 : extend(assembled, size_q, unsigned_q);
          end
        end
        RESP: if (resp_ready) begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_hs.sv
// Bench for data_mem_hs: directed scenarios plus random traffic checked against
// a byte-array model of the memory.
module tb_data_mem_hs;
  localparam int REG_WIDTH  = 64;
  localparam int ADDR_WIDTH = 10;
  localparam int MEM_DEPTH  = 2 ** ADDR_WIDTH;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_width;
  logic [63:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [63:0] resp_rdata;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  mem_m [MEM_DEPTH];

  typedef struct {
    logic        w;
    logic        u;
    logic [1:0]  wd;
    logic [63:0] a;
    logic [63:0] d;
    logic        e;
    logic [63:0] r;
    int          lat;
    bit          use_model;
  } vec_t;

  always #5 clk = ~clk;

  data_mem_hs #(.REG_WIDTH(REG_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_unsigned(req_unsigned),
    .req_width(req_width), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  // Reference: memory is a flat byte array; latency counts cycles after the accept edge.
  function automatic void model(input logic w, input logic u, input logic [1:0] wd,
                                input logic [63:0] a, input logic [63:0] d,
                                output logic e, output logic [63:0] r, output int lat);
    int size;
    size = 1 << wd;
    e    = (a >= 64'(MEM_DEPTH)) || (a + 64'(size) > 64'(MEM_DEPTH));
    r    = '0;
    if (e) lat = 1;
    else   lat = (int'(a % 64'd8) + size > 8) ? 3 : 2;
    if (!e) begin
      if (w) begin
        for (int i = 0; i < size; i++) mem_m[int'(a) + i] = d[8*i +: 8];
      end else begin
        for (int i = 0; i < size; i++) r[8*i +: 8] = mem_m[int'(a) + i];
        if (!u && size < 8 && r[8*size-1]) r = r | ~((64'd1 << (8*size)) - 64'd1);
      end
    end
  endfunction

  task automatic do_req(input logic w, input logic u, input logic [1:0] wd,
                        input logic [63:0] a, input logic [63:0] d,
                        output logic g_err, output logic [63:0] g_rdata,
                        output int g_lat, output logic g_rdy);
    int n;
    @(negedge clk);
    req_write = w; req_unsigned = u; req_width = wd; req_addr = a; req_wdata = d;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    g_err = 1'bx; g_rdata = 'x; g_lat = -1; g_rdy = 1'bx;
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: req_ready still %b after 20 cycles, want 1", req_ready);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    g_lat = 0;
    do begin
      @(negedge clk);
      req_valid = 1'b0;
      g_lat++;
    end while (!resp_valid && g_lat < 10);
    if (!resp_valid) begin
      checks++; errors++;
      $display("FAIL resp_timeout: resp_valid still %b after 10 cycles, want 1", resp_valid);
      return;
    end
    g_err = resp_err; g_rdata = resp_rdata; g_rdy = req_ready;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b1;
    req_write = 1'b0; req_unsigned = 1'b0; req_width = 2'd0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({req_ready, resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b0, 1'b0, 64'd0}) begin
      errors++;
      $display("FAIL reset_state: got ready=%b valid=%b err=%b rdata=%h, want 1 0 0 0",
               req_ready, resp_valid, resp_err, resp_rdata);
    end
  endtask

  // Every byte is written once so later loads never see uninitialised storage.
  task automatic test_init_fill();
    logic e, ge, grdy; logic [63:0] r, gr, d; int lat, glat;
    for (int i = 0; i < MEM_DEPTH / 8; i++) begin
      d = {$urandom, $urandom};
      model(1'b1, 1'b0, 2'd3, 64'(i * 8), d, e, r, lat);
      do_req(1'b1, 1'b0, 2'd3, 64'(i * 8), d, ge, gr, glat, grdy);
      checks++;
      if ({ge, gr, glat, grdy} !== {e, r, lat, 1'b0}) begin
        errors++;
        $display("FAIL init_store @%h: got err=%b rdata=%h lat=%0d ready=%b, want err=%b rdata=%h lat=%0d ready=0",
                 i * 8, ge, gr, glat, grdy, e, r, lat);
      end
    end
  endtask

  task automatic test_directed();
    vec_t v[$];
    logic e, ge, grdy; logic [63:0] r, gr; int lat, glat;
    v.push_back('{1'b1, 1'b0, 2'd3, 64'h10,  64'h8877665544332211, 1'b0, 64'h0,                  2, 1'b0});
    v.push_back('{1'b0, 1'b0, 2'd3, 64'h10,  64'h0,                1'b0, 64'h8877665544332211,   2, 1'b0});
    v.push_back('{1'b1, 1'b0, 2'd2, 64'h1E,  64'hDEADBEEF,         1'b0, 64'h0,                  3, 1'b0});
    v.push_back('{1'b0, 1'b0, 2'd2, 64'h1E,  64'h0,                1'b0, 64'hFFFFFFFFDEADBEEF,   3, 1'b0});
    v.push_back('{1'b0, 1'b1, 2'd2, 64'h1E,  64'h0,                1'b0, 64'h00000000DEADBEEF,   3, 1'b0});
    v.push_back('{1'b0, 1'b0, 2'd0, 64'h20,  64'h0,                1'b0, 64'hFFFFFFFFFFFFFFAD,   2, 1'b0});
    v.push_back('{1'b0, 1'b0, 2'd1, 64'h3FF, 64'h0,                1'b1, 64'h0,                  1, 1'b0});
    v.push_back('{1'b1, 1'b0, 2'd3, 64'h400, 64'hCAFEF00DCAFEF00D, 1'b1, 64'h0,                  1, 1'b0});
    v.push_back('{1'b1, 1'b0, 2'd3, 64'h3FC, 64'h1111111111111111, 1'b1, 64'h0,                  1, 1'b0});
    v.push_back('{1'b0, 1'b1, 2'd2, 64'h3FC, 64'h0,                1'b0, 64'h0,                  0, 1'b1});
    v.push_back('{1'b0, 1'b0, 2'd0, 64'h1_0000_0000, 64'h0,        1'b1, 64'h0,                  1, 1'b0});
    v.push_back('{1'b1, 1'b0, 2'd0, 64'h5,   64'h80,               1'b0, 64'h0,                  2, 1'b0});
    v.push_back('{1'b0, 1'b0, 2'd0, 64'h5,   64'h0,                1'b0, 64'hFFFFFFFFFFFFFF80,   2, 1'b0});
    v.push_back('{1'b0, 1'b1, 2'd0, 64'h5,   64'h0,                1'b0, 64'h80,                 2, 1'b0});
    v.push_back('{1'b0, 1'b1, 2'd0, 64'h4,   64'h0,                1'b0, 64'h0,                  0, 1'b1});
    v.push_back('{1'b0, 1'b1, 2'd0, 64'h6,   64'h0,                1'b0, 64'h0,                  0, 1'b1});
    foreach (v[i]) begin
      model(v[i].w, v[i].u, v[i].wd, v[i].a, v[i].d, e, r, lat);
      if (!v[i].use_model) begin e = v[i].e; r = v[i].r; lat = v[i].lat; end
      do_req(v[i].w, v[i].u, v[i].wd, v[i].a, v[i].d, ge, gr, glat, grdy);
      checks++;
      if ({ge, gr, glat, grdy} !== {e, r, lat, 1'b0}) begin
        errors++;
        $display("FAIL directed[%0d] @%h: got err=%b rdata=%h lat=%0d ready=%b, want err=%b rdata=%h lat=%0d ready=0",
                 i, v[i].a, ge, gr, glat, grdy, e, r, lat);
      end
    end
  endtask

  task automatic test_backpressure();
    logic e, ge, grdy; logic [63:0] exp_r, r, gr; int lat, glat, n;
    model(1'b0, 1'b0, 2'd3, 64'h10, 64'h0, e, exp_r, lat);
    @(negedge clk);
    resp_ready = 1'b0;
    req_write = 1'b0; req_unsigned = 1'b0; req_width = 2'd3; req_addr = 64'h10; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_write = 1'b1; req_wdata = 64'h0123456789ABCDEF;
    n = 0;
    while (!resp_valid && n < 10) begin @(negedge clk); n++; end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({resp_valid, resp_rdata, req_ready} !== {1'b1, exp_r, 1'b0}) begin
        errors++;
        $display("FAIL hold[%0d]: got valid=%b rdata=%h ready=%b, want 1 %h 0",
                 k, resp_valid, resp_rdata, req_ready, exp_r);
      end
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({req_ready, resp_valid} !== 2'b10) begin
      errors++;
      $display("FAIL after_release: got ready=%b valid=%b, want 1 0", req_ready, resp_valid);
    end
    @(posedge clk);
    n = 0;
    do begin @(negedge clk); req_valid = 1'b0; n++; end while (!resp_valid && n < 10);
    model(1'b1, 1'b0, 2'd3, 64'h10, 64'h0123456789ABCDEF, e, r, lat);
    checks++;
    if ({resp_valid, resp_err, n} !== {1'b1, 1'b0, 32'd2}) begin
      errors++;
      $display("FAIL pending_store: got valid=%b err=%b lat=%0d, want 1 0 2", resp_valid, resp_err, n);
    end
    do_req(1'b0, 1'b0, 2'd3, 64'h10, 64'h0, ge, gr, glat, grdy);
    checks++;
    if ({ge, gr, glat} !== {1'b0, 64'h0123456789ABCDEF, 32'd2}) begin
      errors++;
      $display("FAIL pending_store_readback: got err=%b rdata=%h lat=%0d, want 0 0123456789abcdef 2",
               ge, gr, glat);
    end
  endtask

  task automatic test_reset_abort();
    logic e, ge, grdy; logic [63:0] r, gr; int lat, glat;
    model(1'b1, 1'b0, 2'd2, 64'h1E, 64'h11223344, e, r, lat);
    do_req(1'b1, 1'b0, 2'd2, 64'h1E, 64'h11223344, ge, gr, glat, grdy);
    checks++;
    if ({ge, glat} !== {1'b0, 32'd3}) begin
      errors++;
      $display("FAIL abort_setup: got err=%b lat=%0d, want 0 3", ge, glat);
    end
    @(negedge clk);
    req_write = 1'b1; req_width = 2'd2; req_addr = 64'h1E; req_wdata = 64'hAABBCCDD; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mem_m[32'h1E] = 8'hDD;
    mem_m[32'h1F] = 8'hCC;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({resp_valid, req_ready} !== 2'b01) begin
        errors++;
        $display("FAIL abort_idle[%0d]: got valid=%b ready=%b, want 0 1", k, resp_valid, req_ready);
      end
      @(negedge clk);
    end
    do_req(1'b0, 1'b1, 2'd1, 64'h1E, 64'h0, ge, gr, glat, grdy);
    checks++;
    if ({ge, gr} !== {1'b0, 64'hCCDD}) begin
      errors++;
      $display("FAIL abort_beat0_bytes: got err=%b rdata=%h, want 0 000000000000ccdd", ge, gr);
    end
    do_req(1'b0, 1'b1, 2'd1, 64'h20, 64'h0, ge, gr, glat, grdy);
    checks++;
    if ({ge, gr} !== {1'b0, 64'h1122}) begin
      errors++;
      $display("FAIL abort_beat1_bytes: got err=%b rdata=%h, want 0 0000000000001122", ge, gr);
    end
  endtask

  task automatic test_rst_priority();
    logic e, ge, grdy; logic [63:0] r, gr; int lat, glat;
    model(1'b1, 1'b0, 2'd0, 64'h40, 64'hA5, e, r, lat);
    do_req(1'b1, 1'b0, 2'd0, 64'h40, 64'hA5, ge, gr, glat, grdy);
    @(negedge clk);
    rst = 1'b1;
    req_write = 1'b1; req_width = 2'd0; req_addr = 64'h40; req_wdata = 64'h5A; req_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({resp_valid, req_ready} !== 2'b01) begin
        errors++;
        $display("FAIL rst_priority_idle[%0d]: got valid=%b ready=%b, want 0 1", k, resp_valid, req_ready);
      end
      @(negedge clk);
    end
    do_req(1'b0, 1'b1, 2'd0, 64'h40, 64'h0, ge, gr, glat, grdy);
    checks++;
    if ({ge, gr} !== {1'b0, 64'hA5}) begin
      errors++;
      $display("FAIL rst_priority_mem: got err=%b rdata=%h, want 0 00000000000000a5", ge, gr);
    end
  endtask

  task automatic test_random();
    logic w, u, e, ge, grdy; logic [1:0] wd; logic [63:0] a, d, r, gr; int lat, glat, sel;
    for (int i = 0; i < 400; i++) begin
      w   = 1'($urandom_range(0, 1));
      u   = 1'($urandom_range(0, 1));
      wd  = 2'($urandom_range(0, 3));
      d   = {$urandom, $urandom};
      sel = $urandom_range(0, 9);
      if (sel == 0)      a = {$urandom, $urandom};
      else if (sel == 1) a = 64'(MEM_DEPTH - $urandom_range(1, 8));
      else               a = 64'($urandom_range(0, MEM_DEPTH - 1));
      model(w, u, wd, a, d, e, r, lat);
      do_req(w, u, wd, a, d, ge, gr, glat, grdy);
      checks++;
      if ({ge, gr, glat, grdy} !== {e, r, lat, 1'b0}) begin
        errors++;
        $display("FAIL random[%0d] w=%b u=%b wd=%0d @%h: got err=%b rdata=%h lat=%0d ready=%b, want err=%b rdata=%h lat=%0d ready=0",
                 i, w, u, wd, a, ge, gr, glat, grdy, e, r, lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_init_fill();
    test_directed();
    test_backpressure();
    test_reset_abort();
    test_rst_priority();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/data_mem_hs.md
DATA_MEM_HS -- requirements
Module: data_mem_hs

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 64, data width in bits (legal values 32 or 64).
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, byte-address width; MEM_DEPTH = 2^ADDR_WIDTH bytes.
REQ-003 SHALL have parameter LANES = REG_WIDTH/8, derived, bytes per storage word.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on posedge.
REQ-005 SHALL have port rst  in  1  reset; synchronous and active-high.
REQ-006 SHALL have port req_valid  in  1  request present.
REQ-007 SHALL have port req_ready  out  1  block can accept a request.
REQ-008 SHALL have port req_write  in  1  1 = store, 0 = load.
REQ-009 SHALL have port req_unsigned  in  1  1 = zero-extend load, 0 = sign-extend load.
REQ-010 SHALL have port req_width  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = double.
REQ-011 SHALL have port req_addr  in  REG_WIDTH  byte address.
REQ-012 SHALL have port req_wdata  in  REG_WIDTH  store data, LSB-aligned.
REQ-013 SHALL have port resp_valid  out  1  response present.
REQ-014 SHALL have port resp_ready  in  1  consumer accepts response.
REQ-015 SHALL have port resp_rdata  out  REG_WIDTH  extended load data; 0 for stores and errors.
REQ-016 SHALL have port resp_err  out  1  request faulted; no memory effect.

Function
REQ-017 SHALL store MEM_DEPTH bytes as MEM_DEPTH/LANES words of LANES bytes, little-endian, with per-byte write enables.
REQ-018 SHALL accept a request on a posedge where req_valid && req_ready, capturing all req_* fields; req_ready = (state == IDLE).
REQ-019 SHALL implement FSM IDLE -> BEAT0 -> [BEAT1] -> RESP -> IDLE.
REQ-020 SHALL access the word holding req_addr in BEAT0.
REQ-021 SHALL enter BEAT1 only when the access crosses a word boundary, i.e. (addr mod LANES) + size > LANES, and SHALL access the next word there.
REQ-022 SHALL define size = 1 << req_width bytes.
REQ-023 SHALL assert resp_valid exactly in RESP, holding resp_rdata/resp_err stable until the posedge where resp_ready = 1, then return to IDLE.
REQ-024 SHALL give latency from accept edge to resp_valid high of 2 cycles (non-crossing) or 3 cycles (crossing), excluding back-pressure.
REQ-025 SHALL flag err, skip BEAT0/BEAT1 memory effects and go straight to RESP when any req_addr bit above ADDR_WIDTH-1 is nonzero.
REQ-026 SHALL apply the same error handling when addr + size - 1 > MEM_DEPTH - 1 (no wrap-around).
REQ-027 SHALL apply the same error handling when req_width = 3 with REG_WIDTH = 32.
REQ-028 SHALL write only the size selected bytes of req_wdata on a store, split across beats when crossing; untouched bytes keep their value.
REQ-029 SHALL assemble the selected bytes on a load and sign- or zero-extend them to REG_WIDTH per req_unsigned; req_unsigned is ignored when size = LANES.
REQ-030 SHALL reflect all earlier completed stores in every load (no stale data).
REQ-031 SHALL assert no req_ready in the same cycle as resp_valid; one request is in flight at a time.

Reset
REQ-032 SHALL on a rst posedge set state = IDLE, resp_valid = 0, resp_rdata = 0, resp_err = 0; req_ready = 1 the following cycle.
REQ-033 SHALL leave memory contents unaffected by rst.
REQ-034 SHALL let rst abort an in-flight request with no response; bytes written in already-completed beats stay written, remaining beats are dropped.
REQ-035 SHALL let rst take priority over request acceptance in the same cycle.

Verification
REQ-036 SHALL cover: store double 0x8877665544332211 at 0x10, load double 0x10 -> resp_rdata 0x8877665544332211, resp_err 0, resp_valid 2 cycles after each accept.
REQ-037 SHALL cover: store word 0xDEADBEEF at 0x1E (crosses 0x20) -> BEAT1 visited, resp_valid 3 cycles after accept; signed load word 0x1E -> 0xFFFFFFFFDEADBEEF; unsigned load -> 0x00000000DEADBEEF; byte load 0x20 -> 0xFFFFFFFFFFFFFFAD.
REQ-038 SHALL cover: load half at 0x3FF (REG_WIDTH 64, ADDR_WIDTH 10) -> resp_err 1, resp_rdata 0; store at 0x400 -> resp_err 1, memory unchanged.
REQ-039 SHALL cover: hold resp_ready = 0 for 5 cycles -> resp_valid/resp_rdata stable, req_ready 0; new req_valid ignored until 1 cycle after release.
REQ-040 SHALL cover: rst asserted in BEAT1 of a crossing store of 0xAABBCCDD at 0x1E -> no response, bytes 0x1E-0x1F = DD,CC written, 0x20-0x21 unchanged; req_ready 1 one cycle after rst deasserts.
REQ-041 SHALL cover: store byte 0x80 at 0x5, then signed and unsigned byte loads -> 0xFFFFFFFFFFFFFF80 and 0x80; neighbouring bytes 0x4 and 0x6 unchanged.
